// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- 32-bit signed iterative divider with MIPS DIV semantics.
//
// A restoring divider working on operand magnitudes. One quotient bit is
// produced per clock, then a single fix-up cycle applies the signs and loads
// the result registers. Quotient truncates toward zero; remainder takes the
// sign of the dividend. Division by zero completes in one cycle, raises
// divZero and leaves hi/lo untouched.
//
// Ports
//   clk       in   1   system clock, all state changes on posedge
//   reset     in   1   synchronous active-high reset, aborts any operation
//   divStart  in   1   start request, only honoured in IDLE
//   A         in  32   dividend (two's complement), sampled with divStart
//   B         in  32   divisor  (two's complement), sampled with divStart
//   hi        out 32   remainder, registered
//   lo        out 32   quotient, registered
//   divDone   out  1   one-cycle pulse when hi/lo (or divZero) are valid
//   divZero   out  1   divide-by-zero flag, valid with divDone, sticky
//   busy      out  1   high in every state except IDLE
// -----------------------------------------------------------------------------
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        divStart,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divDone,
  output logic        divZero,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [5:0]  count;      // iterations left in CALC
  logic [32:0] rem;        // partial remainder, 33 bits so |A| = 2^31 is exact
  logic [31:0] quo;        // dividend magnitude shifting out, quotient shifting in
  logic [31:0] div_mag;    // |B|
  logic        a_neg;      // remainder takes the dividend's sign
  logic        q_neg;      // quotient negative when operand signs differ

  logic        start_ok;
  logic        start_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  assign start_ok   = (state == IDLE) && divStart && (B != 32'd0);
  assign start_zero = (state == IDLE) && divStart && (B == 32'd0);

  // Negating 0x80000000 yields 0x80000000, which read unsigned is 2^31.
  assign a_mag = A[31] ? (32'd0 - A) : A;
  assign b_mag = B[31] ? (32'd0 - B) : B;

  // One restoring step: bring the next dividend bit into the remainder and
  // subtract the divisor if it fits. A carry out of the shift means the
  // trial value certainly exceeds the divisor.
  assign shifted = {rem[31:0], quo[31]};
  assign fits    = rem[32] || (shifted >= {1'b0, div_mag});
  assign diff    = shifted - {1'b0, div_mag};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok)        state_next = CALC;
        else if (start_zero) state_next = DONE;
      end
      CALC: if (count == 6'd1) state_next = FIX;  // 32nd step is being taken
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  // NOTE: the working registers are reset along with the outputs; they are
  // plain flops, not a memory array, so the reset costs nothing notable and
  // keeps simulation free of X after an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      divZero <= 1'b0;
      count   <= 6'd0;
      rem     <= 33'd0;
      quo     <= 32'd0;
      div_mag <= 32'd0;
      a_neg   <= 1'b0;
      q_neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            rem     <= 33'd0;
            quo     <= a_mag;
            div_mag <= b_mag;
            a_neg   <= A[31];
            q_neg   <= A[31] ^ B[31];
            count   <= 6'd32;
            divZero <= 1'b0;
          end else if (start_zero) begin
            divZero <= 1'b1;
          end
        end
        CALC: begin
          rem   <= fits ? diff : shifted;
          quo   <= {quo[30:0], fits};
          count <= count - 6'd1;
        end
        FIX: begin
          lo <= q_neg ? (32'd0 - quo) : quo;
          hi <= a_neg ? (32'd0 - rem[31:0]) : rem[31:0];
        end
        default: ;
      endcase
    end
  end

  assign divDone = (state == DONE);
  assign busy    = (state != IDLE);

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have ports: clk  input  1  single system clock, all state changes on posedge.
REQ-002 The module SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 The module SHALL have ports: divStart  input  1  start request from the controller, sampled only in IDLE.
REQ-004 The module SHALL have ports: A  input  32  dividend, two's complement, sampled with divStart.
REQ-005 The module SHALL have ports: B  input  32  divisor, two's complement, sampled with divStart.
REQ-006 The module SHALL have ports: hi  output  32  remainder, registered, feeds the HI register.
REQ-007 The module SHALL have ports: lo  output  32  quotient, registered, feeds the LO register.
REQ-008 The module SHALL have ports: divDone  output  1  one-cycle pulse when hi/lo (or divZero) are valid.
REQ-009 The module SHALL have ports: divZero  output  1  divide-by-zero flag, valid with divDone.
REQ-010 The module SHALL have ports: busy  output  1  high in every state except IDLE.

Function
REQ-011 The module SHALL implement states IDLE, CALC, FIX, DONE, with a 6-bit iteration counter.
REQ-012 IDLE with divStart=1 and B!=0 at edge k: latch |A|, |B|, sign(A), sign(A)^sign(B); clear the partial remainder; counter=32; go to CALC.
REQ-013 IDLE with divStart=1 and B==0 at edge k: go directly to DONE with divZero=1; hi/lo keep their previous values.
REQ-014 CALC SHALL perform one restoring step per edge: shift {rem,quo} left 1; if rem>=|B| then subtract and set the quotient LSB; decrement counter.
REQ-015 CALC SHALL run exactly 32 edges (k+1..k+32), then go to FIX.
REQ-016 FIX (edge k+33) SHALL negate the quotient if the sign bits differed, negate the remainder if A was negative, load lo/hi, and go to DONE.
REQ-017 DONE SHALL assert divDone=1 for exactly one cycle (the cycle after edge k+33), then return to IDLE at the next edge.
REQ-018 Latency from divStart sample to divDone high SHALL be 34 cycles for B!=0 and 1 cycle for B==0.
REQ-019 The quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend (MIPS DIV semantics).
REQ-020 For 0x80000000 / 0xFFFFFFFF the result SHALL be lo=0x80000000, hi=0x00000000, divZero=0; no trap.
REQ-021 All magnitude arithmetic SHALL use a 33-bit remainder path so |A|=2^31 is exact.
REQ-022 divStart while busy=1 SHALL be ignored; it SHALL NOT queue or restart the operation.
REQ-023 divZero SHALL be cleared on the next accepted divStart with B!=0 and SHALL otherwise hold.
REQ-024 hi/lo SHALL change only in FIX or on reset; they hold between operations.

Reset
REQ-025 Reset=1 at any edge SHALL force IDLE, hi=0, lo=0, divDone=0, divZero=0, busy=0, counter=0, and SHALL abort any operation in progress.
REQ-026 Reset SHALL take priority over divStart on the same edge.

Verification
REQ-027 A=7, B=2, divStart pulse -> divDone after 34 cycles; lo=0x00000003, hi=0x00000001, divZero=0.
REQ-028 A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; A=7, B=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-029 A=7, B=0 -> divDone and divZero high 1 cycle after start; hi/lo unchanged from the prior result.
REQ-030 A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000 after 34 cycles.
REQ-031 Start 100/7, pulse divStart with 9/3 at cycle 10 -> the second request is ignored; the result is lo=14, hi=2 at cycle 34.
REQ-032 Start any division and assert reset at cycle 15 -> the next cycle shows busy=0 and hi=lo=0; no divDone follows; a new start then completes normally.
